// File: rtl/spi_sched_pkg.sv
// ============================================================================
// Module      : spi_sched_pkg
// Description : Shared types and defaults for the SPI sensor scheduler slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_XFER      = 2'd2,
      ST_GAP       = 2'd3
   } sched_state_e;

   localparam int RX_W        = 32;
   localparam int DEF_GAP_CYC = 8;
   localparam int DEF_TMO_CYC = 400;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin pick; first set request after 'last'.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
   parameter int NREQ = 4,
   parameter int SELW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [SELW-1:0] last,
   output logic            any,
   output logic [SELW-1:0] idx
);

   logic [SELW-1:0] w_cand;

   // Offsets 1..NREQ visit every requester once, ending on 'last' itself.
   always_comb begin
      any    = 1'b0;
      idx    = '0;
      w_cand = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = SELW'((int'(last) + k) % NREQ);
         if (!any && req[w_cand]) begin
            any = 1'b1;
            idx = w_cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_sensor_scheduler.sv
// ============================================================================
// Module      : spi_sensor_scheduler
// Description : Round-robin sharing of one SPI master among NREQ requesters.
//               Optional handshake timeout: define SPI_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sensor_scheduler
   import spi_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int SELW    = 2,
   parameter int GAP_CYC = DEF_GAP_CYC,
   parameter int TMO_CYC = DEF_TMO_CYC,
   parameter int CBITS   = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [NREQ-1:0] rsp_valid,
   output logic [RX_W-1:0] rsp_data,
   output logic            rsp_err,
   output logic            spi_ena,
   output logic [SELW-1:0] spi_cs_sel,
   input  logic            spi_not_busy,
   input  logic [RX_W-1:0] spi_rx_data
);

   localparam logic [1:0] c_IDLE      = ST_IDLE;
   localparam logic [1:0] c_WAIT_BUSY = ST_WAIT_BUSY;
   localparam logic [1:0] c_XFER      = ST_XFER;
   localparam logic [1:0] c_GAP       = ST_GAP;

   localparam logic [SELW-1:0]  c_LAST_RST = SELW'(NREQ - 1);
   // GAP_CYC of 0 or 1 both leave GAP after a single cycle.
   localparam logic [CBITS-1:0] c_GAP_LAST = (GAP_CYC > 1) ? CBITS'(GAP_CYC - 1) : '0;

   logic [1:0]       r_state;
   logic [CBITS-1:0] r_cnt;
   logic [SELW-1:0]  r_last;
   logic [NREQ-1:0]  r_grant;
   logic [NREQ-1:0]  r_rsp_valid;
   logic [RX_W-1:0]  r_rsp_data;
   logic             r_spi_ena;
   logic [SELW-1:0]  r_cs_sel;

   logic             w_any;
   logic [SELW-1:0]  w_idx;
   logic [NREQ-1:0]  w_pick_oh;

`ifdef SPI_SCHED_TIMEOUT_EN
   localparam logic [CBITS-1:0] c_TMO_LAST = (TMO_CYC > 1) ? CBITS'(TMO_CYC - 1) : '0;
   logic r_rsp_err;
   logic w_tmo;
   assign w_tmo   = (r_cnt >= c_TMO_LAST);
   assign rsp_err = r_rsp_err;
`else
   assign rsp_err = 1'b0;
`endif

   rr_picker #(
      .NREQ (NREQ),
      .SELW (SELW)
   ) u_picker (
      .req  (req),
      .last (r_last),
      .any  (w_any),
      .idx  (w_idx)
   );

   assign w_pick_oh = NREQ'(1) << w_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_IDLE;
         r_cnt       <= '0;
         r_last      <= c_LAST_RST;
         r_grant     <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_spi_ena   <= 1'b0;
         r_cs_sel    <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
         r_rsp_err   <= 1'b0;
`endif
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            c_IDLE: begin
               r_spi_ena <= 1'b0;
               r_grant   <= '0;
               if (w_any) begin
                  r_grant   <= w_pick_oh;
                  r_cs_sel  <= w_idx;
                  r_last    <= w_idx;
                  r_spi_ena <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= c_WAIT_BUSY;
               end
            end

            c_WAIT_BUSY: begin
               if (!spi_not_busy) begin
                  r_spi_ena <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= c_XFER;
               end
`ifdef SPI_SCHED_TIMEOUT_EN
               else if (w_tmo) begin
                  r_spi_ena   <= 1'b0;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= r_grant;
                  r_grant     <= '0;
                  r_cnt       <= '0;
                  r_state     <= c_GAP;
               end else begin
                  r_cnt <= r_cnt + CBITS'(1);
               end
`endif
            end

            c_XFER: begin
               // The owner is answered even if its request has since dropped.
               if (spi_not_busy) begin
                  r_rsp_data  <= spi_rx_data;
                  r_rsp_valid <= r_grant;
                  r_grant     <= '0;
                  r_cnt       <= '0;
                  r_state     <= c_GAP;
`ifdef SPI_SCHED_TIMEOUT_EN
                  r_rsp_err   <= 1'b0;
               end else if (w_tmo) begin
                  r_spi_ena   <= 1'b0;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= r_grant;
                  r_grant     <= '0;
                  r_cnt       <= '0;
                  r_state     <= c_GAP;
               end else begin
                  r_cnt <= r_cnt + CBITS'(1);
`endif
               end
            end

            c_GAP: begin
               r_spi_ena <= 1'b0;
               r_grant   <= '0;
               if (r_cnt >= c_GAP_LAST) begin
                  r_cnt   <= '0;
                  r_state <= c_IDLE;
               end else begin
                  r_cnt <= r_cnt + CBITS'(1);
               end
            end

            default: begin
               r_spi_ena <= 1'b0;
               r_grant   <= '0;
               r_cnt     <= '0;
               r_state   <= c_IDLE;
            end
         endcase
      end
   end

   assign grant      = r_grant;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign spi_ena    = r_spi_ena;
   assign spi_cs_sel = r_cs_sel;

endmodule

`default_nettype wire

// File: tb/tb_spi_sensor_scheduler.sv
// ============================================================================
// Module      : tb_spi_sensor_scheduler
// Description : Scoreboard bench for spi_sensor_scheduler with a scripted master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_sensor_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic [3:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        spi_ena;
   logic [1:0]  spi_cs_sel;
   logic        spi_not_busy;
   logic [31:0] spi_rx_data;

   int n_checks = 0;
   int n_errors = 0;
   bit done     = 1'b0;

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      logic        e;
   } exp_t;

   exp_t sb[$];

   spi_sensor_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .grant        (grant),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .spi_ena      (spi_ena),
      .spi_cs_sel   (spi_cs_sel),
      .spi_not_busy (spi_not_busy),
      .spi_rx_data  (spi_rx_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] v, input logic [31:0] d, input logic e);
      exp_t t;
      t.v = v;
      t.d = d;
      t.e = e;
      sb.push_back(t);
   endtask

   // Monitor: pops the scoreboard on every response pulse, checks invariants.
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge clk);
         if (!done) begin
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("ena_has_owner", 32'(!(spi_ena && grant == 4'b0)), 32'd1);
            if (rsp_valid != 4'b0) begin
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
                  chk("rsp_data", rsp_data, e.d);
                  chk("rsp_err", 32'(rsp_err), 32'(e.e));
               end
            end
         end
      end
   end

   task automatic wait_ena(output int n);
      n = 0;
      while (!spi_ena && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!spi_ena) chk("ena_wait_timeout", 32'd0, 32'd1);
   endtask

   // One transaction; bdly = cycles before the master goes busy, xlen = busy cycles.
   task automatic txn(input int idx, input logic [31:0] rx, input int bdly,
                      input int xlen, input logic [3:0] req_mid);
      logic [3:0] oh;
      oh = 4'(1 << idx);
      chk("txn_grant", 32'(grant), 32'(oh));
      chk("txn_cs_sel", 32'(spi_cs_sel), 32'(idx));
      repeat (bdly) @(negedge clk);
      chk("txn_ena_held", 32'(spi_ena), 32'd1);
      spi_not_busy = 1'b0;
      @(negedge clk);
      chk("txn_ena_drop", 32'(spi_ena), 32'd0);
      chk("txn_grant_xfer", 32'(grant), 32'(oh));
      req = req_mid;
      repeat (xlen) @(negedge clk);
      spi_rx_data  = rx;
      spi_not_busy = 1'b1;
      push_exp(oh, rx, 1'b0);
      @(negedge clk);
      chk("txn_grant_clear", 32'(grant), 32'd0);
   endtask

   initial begin
      int n;
      rst          = 1'b1;
      req          = 4'b0;
      spi_not_busy = 1'b1;
      spi_rx_data  = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_spi_ena", 32'(spi_ena), 32'd0);
      chk("rst_cs_sel", 32'(spi_cs_sel), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_ena", 32'(spi_ena), 32'd0);

      // Single request, slow master, then re-grant spacing with req held.
      req = 4'b0001;
      @(negedge clk);
      chk("t1_latency_grant", 32'(grant), 32'h1);
      chk("t1_latency_ena", 32'(spi_ena), 32'd1);
      txn(0, 32'hDEADBEEF, 2, 32, 4'b0001);
      wait_ena(n);
      chk("t1_regrant_gap", 32'(n), 32'd9);
      txn(0, 32'h0000_1111, 0, 0, 4'b0001);
      req = 4'b0;
      repeat (12) @(negedge clk);

      // Fresh reset so requester 0 wins first in the round-robin sweep.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1111;
      wait_ena(n);
      chk("t2_first_latency", 32'(n), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            wait_ena(n);
            chk("t2_period", 32'(n), 32'd9);
         end
         txn(i, 32'hA5A5_0000 + 32'(i), 0, 1 + i, 4'b1111);
      end
      req = 4'b0;
      repeat (12) @(negedge clk);

      // Set last=2, then wrap: 0011 gives 0 then 1.
      req = 4'b0100;
      wait_ena(n);
      txn(2, 32'h0000_0222, 0, 0, 4'b0100);
      req = 4'b0011;
      wait_ena(n);
      chk("t3_wrap_gap", 32'(n), 32'd9);
      txn(0, 32'h1234_5678, 0, 2, 4'b0011);
      wait_ena(n);
      txn(1, 32'h8765_4321, 0, 2, 4'b0011);
      req = 4'b0;
      repeat (12) @(negedge clk);

      // Request dropped mid-transfer still gets its response.
      req = 4'b0010;
      wait_ena(n);
      txn(1, 32'hCAFE_F00D, 1, 4, 4'b0000);
      repeat (12) @(negedge clk);
      chk("t4_no_regrant", 32'(grant), 32'd0);
      chk("t4_no_ena", 32'(spi_ena), 32'd0);

      // Reset during XFER: no response, last returns to 3.
      req = 4'b0100;
      wait_ena(n);
      chk("t5_grant", 32'(grant), 32'h4);
      spi_not_busy = 1'b0;
      @(negedge clk);
      chk("t5_in_xfer", 32'(spi_ena), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      req = 4'b0;
      @(negedge clk);
      chk("t5_rst_grant", 32'(grant), 32'd0);
      chk("t5_rst_ena", 32'(spi_ena), 32'd0);
      chk("t5_rst_cs_sel", 32'(spi_cs_sel), 32'd0);
      spi_rx_data  = 32'hBAD0_BAD0;
      spi_not_busy = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      req = 4'b1000;
      @(negedge clk);
      chk("t5_after_rst_grant", 32'(grant), 32'h8);
      txn(3, 32'h0BAD_CAFE, 0, 0, 4'b1000);
      req = 4'b0;
      repeat (12) @(negedge clk);

`ifdef SPI_SCHED_TIMEOUT_EN
      // Master never goes busy: abort after TMO_CYC cycles.
      req = 4'b0001;
      wait_ena(n);
      push_exp(4'b0001, 32'h0, 1'b1);
      repeat (399) @(negedge clk);
      chk("t6_ena_before_tmo", 32'(spi_ena), 32'd1);
      @(negedge clk);
      chk("t6_ena_after_tmo", 32'(spi_ena), 32'd0);
      chk("t6_grant_after_tmo", 32'(grant), 32'd0);
      req = 4'b0;
      repeat (12) @(negedge clk);
`endif

      repeat (5) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got hang expected finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/spi_sensor_scheduler.md
Name: spi_sensor_scheduler

Overview:
- Shares one SPI master among NREQ sensor readers (thermocouple channels, other SPI sensors) using round-robin arbitration.
- Sequences each transaction against the master's level handshake (spi_ena / spi_not_busy).
- Selects the chip-select index for the granted channel and returns the 32-bit RX word to that requester.
- Enforces a CS-deselect gap between transactions.

Parameters:
- NREQ, 4, number of requesters.
- SELW, 2, width of spi_cs_sel; 2^SELW >= NREQ.
- GAP_CYC, 8, idle cycles between transactions; 0 allowed.
- TMO_CYC, 400, handshake timeout in cycles (used only with the optional feature).
- CBITS, 12, counter width; 2^CBITS > max(GAP_CYC, TMO_CYC).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester transaction request, level
- grant  out  NREQ  one-hot owner of the current transaction, or all zero
- rsp_valid  out  NREQ  one-cycle completion pulse to the owner
- rsp_data  out  32  RX word of the last completed transaction
- rsp_err  out  1  qualifies rsp_valid; 1 = transaction aborted
- spi_ena  out  1  start request to the SPI master
- spi_cs_sel  out  SELW  chip-select index of the granted requester
- spi_not_busy  in  1  SPI master idle flag
- spi_rx_data  in  32  SPI master RX word; valid while spi_not_busy=1 after a transfer

Behaviour:
- Reset values: grant=0, rsp_valid=0, rsp_data=0, rsp_err=0, spi_ena=0, spi_cs_sel=0, state=IDLE, cnt=0, last=NREQ-1 (so requester 0 wins first).
- State IDLE, when req != 0:
  - Pick the first set bit searching from (last+1) mod NREQ upward, with wrap.
  - At the next edge: grant=onehot(idx), spi_cs_sel=idx, last=idx, spi_ena=1, cnt=0, go to WAIT_BUSY.
  - Latency from req to grant/spi_ena is 1 cycle.
- State WAIT_BUSY: hold spi_ena=1 until spi_not_busy=0 is sampled; then spi_ena=0 and go to XFER.
- State XFER: wait for spi_not_busy=1, then at that edge:
  - rsp_data=spi_rx_data, rsp_err=0, rsp_valid[idx]=1 for exactly one cycle;
  - grant=0, cnt=0, go to GAP.
- State GAP:
  - spi_ena=0, grant=0.
  - cnt increments each cycle; at cnt=GAP_CYC-1 go to IDLE.
  - GAP_CYC=0: return to IDLE on the cycle after completion.
- Any unused state encoding goes to IDLE with spi_ena=0.
- spi_cs_sel holds its value until the next grant; it does not return to 0.
- Dropped request: if req[idx] deasserts mid-transaction, the transaction still completes and rsp_valid still pulses. req is sampled only in IDLE.
- New requests: requests arriving during WAIT_BUSY, XFER or GAP wait; no preemption.
- Single requester held high: re-granted every 3+GAP_CYC cycles minimum.
- Reset mid-transaction: everything returns to reset values on the next edge, spi_ena drops immediately, and no rsp_valid is issued.
- Invariants:
  - grant is one-hot or zero.
  - spi_ena=1 only in WAIT_BUSY.
  - |rsp_valid <= 1 bit set.
  - grant != 0 from the grant edge until the completion edge, inclusive of WAIT_BUSY and XFER.

Optional Feature:
- Macro: SPI_SCHED_TIMEOUT_EN.
- Defined: cnt counts in WAIT_BUSY and XFER and resets on each state entry. If cnt reaches TMO_CYC, then at that edge:
  - spi_ena=0, rsp_data=0, rsp_err=1, rsp_valid[idx]=1 for one cycle;
  - grant=0, go to GAP.
- Undefined: no timeout, the scheduler waits indefinitely, and rsp_err is constant 0.

Decomposition:
- Package spi_sched_pkg holds:
  - state enum {IDLE, WAIT_BUSY, XFER, GAP}, 2 bits;
  - RX_W=32;
  - default GAP_CYC and TMO_CYC constants.
- Sub-module rr_picker (combinational):
  - inputs: req, last;
  - outputs: any, idx.
  - It is reused by other shared-bus arbiters.

Test Plan:
- Single request: req=0001, master drops spi_not_busy 2 cycles after spi_ena, then raises it 32 cycles later with rx=0xDEADBEEF -> grant=0001 1 cycle after req; spi_ena falls the cycle after not_busy=0; rsp_valid=0001 for one cycle with rsp_data=0xDEADBEEF; next grant no sooner than 8 cycles later.
- Round robin: req=1111 held for 4 transactions -> grant order 0001, 0010, 0100, 1000; spi_cs_sel = 0, 1, 2, 3.
- Wrap with last=2: req=0011 -> grant=0001, then 0010.
- Dropped request: req[1] drops during XFER -> transaction completes and rsp_valid=0010 still pulses.
- Reset during XFER -> next cycle grant=0, spi_ena=0, no rsp_valid; the next req=1000 is granted first because last=3 after reset.
- With SPI_SCHED_TIMEOUT_EN: spi_not_busy held 1 after spi_ena -> at 400 cycles rsp_err=1, rsp_valid pulses, rsp_data=0, state=GAP.
